alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator-side front end for new_alu. It accepts ALU commands (op, A, B) over a valid/ready stream and buffers them in a small FIFO. It drives the ALU operand/op inputs one command at a time, waits the ALU's fixed latency, then captures o_result/o_status. The captured result is returned on a valid/ready response stream, tagged with its op. It sits between the test/control logic and new_alu, sharing the ALU's clock and reset.

Parameters:
N, 4, op code width (matches new_alu N)
M, 8, operand width (matches new_alu M)
K, 8, result width (matches new_alu K)
LAT, 1, ALU latency in clock edges from operand change to stable result (0 = combinational)
DEPTH, 4, command FIFO depth, power of two, >=2

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  FIFO can accept command
i_cmd_op  in  N  command op code
i_cmd_A  in  M  command operand A
i_cmd_B  in  M  command operand B
o_alu_op  out  N  to new_alu i_op
o_alu_arg_A  out  M  to new_alu i_arg_A
o_alu_arg_B  out  M  to new_alu i_arg_B
i_alu_result  in  K  from new_alu o_result
i_alu_status  in  4  from new_alu o_status
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  consumer takes response
o_rsp_result  out  K  captured result
o_rsp_status  out  4  captured status
o_rsp_op  out  N  op code that produced the response
o_busy  out  1  FSM not IDLE or FIFO non-empty
o_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock with i_reset high clears every output to 0 (o_cmd_ready=0 while i_reset is high), empties the FIFO, sets the FSM to IDLE and clears the counter. o_cmd_ready=1 on the first cycle after reset release.
- Reset mid-operation: in-flight and buffered commands are discarded. No response is produced for them.
- Push: occurs on an edge where i_cmd_valid && o_cmd_ready. o_cmd_ready = !full, registered from the count; there is no full-bypass. A push and pop on the same edge leave the count unchanged. A push when full cannot occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally. o_count ranges 0..DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head on that edge and load o_alu_op/arg_A/arg_B with it. Set cnt<=LAT and go to WAIT. If the FIFO is empty, stay in IDLE and hold the ALU drive values.
- WAIT: ALU drive values are held stable. If cnt!=0, cnt<=cnt-1. If cnt==0, latch i_alu_result into o_rsp_result, i_alu_status into o_rsp_status, and the popped op into o_rsp_op. Set o_rsp_valid<=1 and go to RESP.
- RESP: hold all o_rsp_* stable while i_rsp_ready=0. On an edge with i_rsp_ready=1, set o_rsp_valid<=0 and go to IDLE.
- Timing, idle sequencer: a command accepted at edge E0 is popped at E1 and o_rsp_valid rises after edge E1+LAT+1. Command-to-response latency is LAT+2 cycles.
- Throughput: one command per LAT+3 cycles with i_rsp_ready held high.
- The FIFO continues to accept commands in WAIT/RESP. Backpressure on the response stream stalls the FSM only, not the FIFO, until the FIFO is full.
- Commands complete strictly in order. Responses are never dropped or duplicated.
- Width rules: result and status are passed through unmodified. No arithmetic is performed on data.

Decomposition:
- Package alu_seq_pkg:
  - state enum {IDLE, WAIT, RESP}
  - localparam STATUS_W=4
  - function clog2-based counter width helper
- Sub-module cmd_fifo (synchronous FIFO, DEPTH x (N+2M), push/pop/full/empty/count), instantiated once.
- FSM and capture registers live in the top module.

Test Plan:
Bench uses new_alu with default N=4, M=8, K=8, LAT=1. Expected values come from a bench reference model of new_alu.
- Single command: op=4'b1000, A=0xCC, B=0xFE accepted at E0 -> alu args driven after E1; o_rsp_valid after E3; o_rsp_op=4'b1000; result/status equal the model output.
- Back-to-back: push ops 4'b0000, 4'b0001, 4'b1000 (A=0xCC, B=0xFE) on 3 consecutive edges with i_rsp_ready=1 -> three responses in the same op order, spaced exactly 4 cycles apart.
- Full FIFO: hold i_rsp_ready=0 and push 6 commands -> 1 in RESP, o_count=4, o_cmd_ready=0; release ready -> all 5 remaining complete in order, none lost.
- Response backpressure: i_rsp_ready=0 for 10 cycles in RESP -> o_rsp_* stable and o_alu_* unchanged; ready pulse for 1 cycle -> exactly one handshake.
- Reset mid-WAIT: assert i_reset for 1 cycle while 3 commands are pending -> next cycle all outputs 0, o_count=0; no stale response after release.
- Simultaneous push/pop with o_count=2 -> o_count stays 2; the popped command is the older one.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and helpers for the ALU command sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// FSM state encoding, status width and FIFO counter width helper.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int STATUS_W = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready streams of the ALU command sequencer.
// Latency: n/a (wiring only). Backpressure: standard valid/ready on both streams.
// Signal names are from the sequencer's point of view (slave modport).
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 8
) ();

    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [N-1:0]        i_cmd_op;
    logic [M-1:0]        i_cmd_A;
    logic [M-1:0]        i_cmd_B;

    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [K-1:0]        o_rsp_result;
    logic [STATUS_W-1:0] o_rsp_status;
    logic [N-1:0]        o_rsp_op;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_A, i_cmd_B, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_op
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_A, i_cmd_B, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_op
    );

endinterface

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Generic synchronous show-ahead FIFO, DEPTH x W.
// Latency: push visible at head one cycle later. Backpressure: o_push_rdy is a
// registered !full; pops are only issued by the user when not empty.
module cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_push_vld,
    output logic                      o_push_rdy,
    input  logic [W-1:0]              i_push_dat,
    input  logic                      i_pop,
    output logic [W-1:0]              o_pop_dat,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_push_rdy;
    logic          w_push;
    logic [CW-1:0] w_count_nxt;

    assign w_push = i_push_vld && r_push_rdy;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, i_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_push_rdy <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            // Ready looks one edge ahead so it never over-admits.
            r_push_rdy <= (w_count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_pop_dat  = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_push_rdy = r_push_rdy;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to new_alu and returns results.
// Latency: LAT+2 cycles command-to-response when idle. Backpressure: response
// stalls the FSM only; the command FIFO keeps accepting until full.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int K     = 8,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    alu_cmd_sequencer_if.slave        bus,
    output logic [N-1:0]              o_alu_op,
    output logic [M-1:0]              o_alu_arg_A,
    output logic [M-1:0]              o_alu_arg_B,
    input  logic [K-1:0]              i_alu_result,
    input  logic [STATUS_W-1:0]       i_alu_status,
    output logic                      o_busy,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef struct packed {
        logic [N-1:0] op;
        logic [M-1:0] a;
        logic [M-1:0] b;
    } cmd_t;

    cmd_t                w_push_dat;
    cmd_t                w_head;
    logic                w_empty;
    logic                w_cmd_rdy;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_pop;
    logic                w_dec;
    logic                w_capture;
    logic                w_rsp_done;

    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_alu_op;
    logic [M-1:0]        r_alu_a;
    logic [M-1:0]        r_alu_b;
    logic                r_rsp_vld;
    logic [K-1:0]        r_rsp_result;
    logic [STATUS_W-1:0] r_rsp_status;
    logic [N-1:0]        r_rsp_op;

    assign w_push_dat = '{op: bus.i_cmd_op, a: bus.i_cmd_A, b: bus.i_cmd_B};

    cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push_vld (bus.i_cmd_valid),
        .o_push_rdy (w_cmd_rdy),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_empty    (w_empty),
        .o_count    (o_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_empty)          w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0)       w_state_nxt = RESP;
            RESP:    if (bus.i_rsp_ready)   w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_dec      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            IDLE:    w_pop      = !w_empty;
            WAIT: begin
                     w_dec      = (r_cnt != '0);
                     w_capture  = (r_cnt == '0);
            end
            RESP:    w_rsp_done = bus.i_rsp_ready;
            default: ;
        endcase
    end

    // ALU drive values only change on a pop, so they stay stable through WAIT/RESP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_rsp_op     <= '0;
        end else begin
            if (w_pop) begin
                r_alu_op <= w_head.op;
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
                r_cnt    <= CNT_W'(LAT);
            end
            if (w_dec) r_cnt <= r_cnt - 1'b1;
            if (w_capture) begin
                r_rsp_result <= i_alu_result;
                r_rsp_status <= i_alu_status;
                r_rsp_op     <= r_alu_op;
                r_rsp_vld    <= 1'b1;
            end
            if (w_rsp_done) r_rsp_vld <= 1'b0;
        end
    end

    assign bus.o_cmd_ready  = w_cmd_rdy;
    assign bus.o_rsp_valid  = r_rsp_vld;
    assign bus.o_rsp_result = r_rsp_result;
    assign bus.o_rsp_status = r_rsp_status;
    assign bus.o_rsp_op     = r_rsp_op;

    assign o_alu_op    = r_alu_op;
    assign o_alu_arg_A = r_alu_a;
    assign o_alu_arg_B = r_alu_b;
    assign o_busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered (LAT=1) new_alu stand-in.
// Responses are scoreboarded in order against the commands the bench pushed.
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } tcmd_t;

    logic       clk;
    logic       rst;
    logic [3:0] alu_op;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [7:0] alu_res;
    logic [3:0] alu_sts;
    logic       busy;
    logic [2:0] count;

    int    errors   = 0;
    int    checks   = 0;
    int    timeouts = 0;
    int    stray    = 0;
    int    hs_cnt   = 0;
    int    cyc      = 0;
    int    hs_cyc[$];
    tcmd_t exp_q[$];

    alu_cmd_sequencer_if #(.N(4), .M(8), .K(8)) ifc ();

    alu_cmd_sequencer #(
        .N(4), .M(8), .K(8), .LAT(1), .DEPTH(4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .bus          (ifc),
        .o_alu_op     (alu_op),
        .o_alu_arg_A  (alu_A),
        .o_alu_arg_B  (alu_B),
        .i_alu_result (alu_res),
        .i_alu_status (alu_sts),
        .o_busy       (busy),
        .o_count      (count)
    );

    // new_alu reference: status = {carry/borrow, zero, negative, parity}.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] s;
        case (op)
            4'b0000: s = {1'b0, a} + {1'b0, b};
            4'b0001: s = {1'b0, a} - {1'b0, b};
            4'b1000: s = {1'b0, a & b};
            default: s = {1'b0, a ^ b};
        endcase
        return {s[8], (s[7:0] == 8'h00), s[7], ^s[7:0], s[7:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        {alu_sts, alu_res} <= alu_ref(alu_op, alu_A, alu_B);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Values seen at the falling edge are what the next rising edge will act on.
    always @(negedge clk) begin
        tcmd_t       e;
        logic [11:0] r;
        if (!rst && ifc.i_cmd_valid && ifc.o_cmd_ready)
            exp_q.push_back('{op: ifc.i_cmd_op, a: ifc.i_cmd_A, b: ifc.i_cmd_B});
        if (!rst && ifc.o_rsp_valid && ifc.i_rsp_ready) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                stray++;
            end else begin
                e = exp_q.pop_front();
                r = alu_ref(e.op, e.a, e.b);
                chk("rsp_op", ifc.o_rsp_op, e.op);
                chk("rsp_result", ifc.o_rsp_result, r[7:0]);
                chk("rsp_status", ifc.o_rsp_status, r[11:8]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        ifc.i_cmd_valid = v;
        ifc.i_cmd_op    = op;
        ifc.i_cmd_A     = a;
        ifc.i_cmd_B     = b;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        drive(1'b1, op, a, b);
        for (int t = 0; t < 100; t++) begin
            ok = ifc.o_cmd_ready;
            tick();
            if (ok) break;
        end
        if (!ok) timeouts++;
        ifc.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_vld();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (ifc.o_rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) timeouts++;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0 && !busy && !ifc.o_rsp_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) timeouts++;
    endtask

    initial begin
        int hs0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        ifc.i_rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", ifc.o_cmd_ready, 1'b0);
        chk("rst_rsp_valid", ifc.o_rsp_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_op", alu_op, 4'h0);
        chk("rst_rsp_result", ifc.o_rsp_result, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", ifc.o_cmd_ready, 1'b1);

        // Single command: accepted at E0, ALU driven after E1, response after E3.
        ifc.i_rsp_ready = 1'b1;
        drive(1'b1, 4'b1000, 8'hCC, 8'hFE);
        tick();
        ifc.i_cmd_valid = 1'b0;
        chk("single_count_e0", count, 3'd1);
        tick();
        chk("single_alu_op", alu_op, 4'b1000);
        chk("single_alu_A", alu_A, 8'hCC);
        chk("single_alu_B", alu_B, 8'hFE);
        chk("single_vld_e1", ifc.o_rsp_valid, 1'b0);
        tick();
        chk("single_vld_e2", ifc.o_rsp_valid, 1'b0);
        tick();
        chk("single_vld_e3", ifc.o_rsp_valid, 1'b1);
        chk("single_op", ifc.o_rsp_op, 4'b1000);
        chk("single_result", ifc.o_rsp_result, 8'hCC);
        chk("single_status", ifc.o_rsp_status, 4'b0010);
        tick();
        chk("single_vld_e4", ifc.o_rsp_valid, 1'b0);
        chk("single_busy_e4", busy, 1'b0);

        // Back-to-back pushes: responses in order, four cycles apart.
        hs_cyc.delete();
        drive(1'b1, 4'b0000, 8'hCC, 8'hFE); tick();
        drive(1'b1, 4'b0001, 8'hCC, 8'hFE); tick();
        drive(1'b1, 4'b1000, 8'hCC, 8'hFE); tick();
        ifc.i_cmd_valid = 1'b0;
        drain();
        chk("b2b_rsp_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_gap_1", hs_cyc[1] - hs_cyc[0], 4);
            chk("b2b_gap_2", hs_cyc[2] - hs_cyc[1], 4);
        end

        // Response backpressure, then a pop coinciding with a push at count 2.
        ifc.i_rsp_ready = 1'b0;
        hs0 = hs_cnt;
        push(4'h2, 8'h11, 8'h22);
        push(4'h3, 8'h33, 8'h44);
        push(4'h4, 8'h55, 8'h66);
        wait_rsp_vld();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rsp_valid", ifc.o_rsp_valid, 1'b1);
            chk("bp_rsp_op", ifc.o_rsp_op, 4'h2);
            chk("bp_rsp_result", ifc.o_rsp_result, 8'h33);
            chk("bp_alu_op", alu_op, 4'h2);
            chk("bp_alu_A", alu_A, 8'h11);
        end
        chk("bp_count", count, 3'd2);
        ifc.i_rsp_ready = 1'b1;
        tick();
        ifc.i_rsp_ready = 1'b0;
        drive(1'b1, 4'h5, 8'h77, 8'h88);
        tick();
        ifc.i_cmd_valid = 1'b0;
        chk("pushpop_count", count, 3'd2);
        chk("pushpop_alu_op", alu_op, 4'h3);
        chk("pushpop_alu_A", alu_A, 8'h33);
        chk("bp_one_handshake", hs_cnt - hs0, 1);
        chk("bp_vld_after_pulse", ifc.o_rsp_valid, 1'b0);
        ifc.i_rsp_ready = 1'b1;
        drain();
        chk("bp_total_rsp", hs_cnt - hs0, 4);

        // Full FIFO: five accepted, sixth waits for space.
        ifc.i_rsp_ready = 1'b0;
        hs0 = hs_cnt;
        push(4'h6, 8'h10, 8'h01);
        push(4'h7, 8'h20, 8'h02);
        push(4'h9, 8'h30, 8'h03);
        push(4'hA, 8'h40, 8'h04);
        push(4'hB, 8'h50, 8'h05);
        drive(1'b1, 4'hC, 8'h60, 8'h06);
        repeat (4) tick();
        chk("full_count", count, 3'd4);
        chk("full_cmd_ready", ifc.o_cmd_ready, 1'b0);
        chk("full_rsp_valid", ifc.o_rsp_valid, 1'b1);
        chk("full_no_rsp_yet", hs_cnt - hs0, 0);
        ifc.i_rsp_ready = 1'b1;
        push(4'hC, 8'h60, 8'h06);
        drain();
        chk("full_total_rsp", hs_cnt - hs0, 6);

        // Reset while in WAIT with three commands pending.
        drive(1'b1, 4'h0, 8'h01, 8'h02); tick();
        drive(1'b1, 4'h1, 8'h03, 8'h04); tick();
        drive(1'b1, 4'h8, 8'h05, 8'h06); tick();
        ifc.i_cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp_valid", ifc.o_rsp_valid, 1'b0);
        chk("mid_rst_cmd_ready", ifc.o_cmd_ready, 1'b0);
        chk("mid_rst_alu_op", alu_op, 4'h0);
        chk("mid_rst_alu_A", alu_A, 8'h00);
        chk("mid_rst_alu_B", alu_B, 8'h00);
        chk("mid_rst_rsp_op", ifc.o_rsp_op, 4'h0);
        chk("mid_rst_rsp_status", ifc.o_rsp_status, 4'h0);
        exp_q.delete();
        hs0 = hs_cnt;
        rst = 1'b0;
        repeat (15) tick();
        chk("post_rst_no_rsp", hs_cnt - hs0, 0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ready", ifc.o_cmd_ready, 1'b1);

        chk("stray_responses", stray, 0);
        chk("timeouts", timeouts, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
